// File: rtl/wb_async_pkg.sv
// Shared definitions for the async Wishbone bridge byte link.
// Imported by the host-side initiator (host_async) and the bridge-side controller.
//   state_e             : transaction FSM states
//   CmdWeBit            : position of the write flag in the command byte
//   CmdAdrWidth         : width of the register address field in the command byte
//   WriteAckByteDefault : response byte that signals a successful write
//   cmd_byte()          : builds {we, 3'b000, adr} for the command byte
package wb_async_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSendCmd,
    StSendData,
    StWaitResp
  } state_e;

  localparam int unsigned CmdWeBit    = 7;
  localparam int unsigned CmdAdrWidth = 4;

  localparam logic [7:0] WriteAckByteDefault = 8'h01;

  function automatic logic [7:0] cmd_byte(input logic                   we,
                                          input logic [CmdAdrWidth-1:0] adr);
    logic [7:0] b;
    b                  = '0;
    b[CmdWeBit]        = we;
    b[CmdAdrWidth-1:0] = adr;
    return b;
  endfunction

endpackage

// File: rtl/timeout_cnt.sv
// Response-timeout counter for host_async.
// Built only when HOST_ASYNC_TIMEOUT_EN is defined; otherwise this file is empty.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   clear_i   : synchronously return the count to zero (has priority)
//   enable_i  : advance the count by one
//   expired_o : count has reached Cycles-1
`ifdef HOST_ASYNC_TIMEOUT_EN
module timeout_cnt #(
  parameter int unsigned Cycles = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned Width = (Cycles > 1) ? $clog2(Cycles) : 1;
  localparam logic [Width-1:0] Last = Width'(Cycles - 1);

  logic [Width-1:0] count_q, count_d;

  assign expired_o = (count_q == Last);

  // Saturate at the terminal value so a held enable never wraps back to zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/host_async.sv
// Host-side initiator for the async Wishbone bridge byte link.
// Takes one read/write request at a time, sends the command byte (plus data byte for writes)
// on the TX byte stream, waits for a single response byte on RX and returns it.
// Optional feature macro: HOST_ASYNC_TIMEOUT_EN adds a response timeout of TimeoutCycles.
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  : request handshake; req_we_i, req_adr_i, req_dat_i
//   rsp_valid_o                : one-cycle response pulse with rsp_dat_o / rsp_err_o
//   tx_req_o / tx_ready_i      : byte toward serial TX (tx_data_o), held until accepted
//   rx_req_i / rx_data_i       : one-cycle received-byte strobe and its data
//   stray_o                    : one-cycle pulse for an RX byte nobody was waiting for
module host_async
  import wb_async_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1000000,
  parameter logic [7:0]  WriteAckByte  = WriteAckByteDefault
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [CmdAdrWidth-1:0] req_adr_i,
  input  logic [7:0]             req_dat_i,
  output logic                   rsp_valid_o,
  output logic [7:0]             rsp_dat_o,
  output logic                   rsp_err_o,
  output logic                   tx_req_o,
  input  logic                   tx_ready_i,
  output logic [7:0]             tx_data_o,
  input  logic                   rx_req_i,
  input  logic [7:0]             rx_data_i,
  output logic                   stray_o
);

  state_e state_q, state_d;

  logic       we_q, we_d;
  logic [7:0] dat_q, dat_d;
  logic       tx_req_q, tx_req_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_dat_q, rsp_dat_d;
  logic       rsp_err_q, rsp_err_d;
  logic       stray_q, stray_d;

  logic       tx_accept;
  logic       timeout_hit;

  // tx_req_q is always high in the send states, so tx_ready_i alone marks acceptance there.
  assign tx_accept = tx_req_q && tx_ready_i;

`ifdef HOST_ASYNC_TIMEOUT_EN
  logic timeout_expired;

  timeout_cnt #(
    .Cycles(TimeoutCycles)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (state_q != StWaitResp),
    .enable_i (state_q == StWaitResp),
    .expired_o(timeout_expired)
  );

  // A byte arriving in the terminal cycle wins over the timeout.
  assign timeout_hit = timeout_expired && !rx_req_i;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TimeoutCycles;
  assign timeout_hit           = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          state_d = StSendCmd;
        end
      end
      StSendCmd: begin
        if (tx_accept) begin
          state_d = we_q ? StSendData : StWaitResp;
        end
      end
      StSendData: begin
        if (tx_accept) begin
          state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        if (rx_req_i || timeout_hit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: ready is decoded from state, everything else is registered.
  always_comb begin
    req_ready_o = (state_q == StIdle);

    we_d        = we_q;
    dat_d       = dat_q;
    tx_req_d    = tx_req_q;
    tx_data_d   = tx_data_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    // Includes a byte landing in the same cycle the last TX byte leaves.
    stray_d     = rx_req_i && (state_q != StWaitResp);

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          we_d      = req_we_i;
          dat_d     = req_dat_i;
          tx_req_d  = 1'b1;
          tx_data_d = cmd_byte(req_we_i, req_adr_i);
        end
      end
      StSendCmd: begin
        if (tx_accept) begin
          if (we_q) begin
            tx_data_d = dat_q;
          end else begin
            tx_req_d = 1'b0;
          end
        end
      end
      StSendData: begin
        if (tx_accept) begin
          tx_req_d = 1'b0;
        end
      end
      StWaitResp: begin
        if (rx_req_i) begin
          rsp_valid_d = 1'b1;
          rsp_dat_d   = rx_data_i;
          rsp_err_d   = we_q && (rx_data_i != WriteAckByte);
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_dat_d   = 8'hFF;
          rsp_err_d   = 1'b1;
        end
      end
      default: begin
        tx_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q        <= 1'b0;
      dat_q       <= '0;
      tx_req_q    <= 1'b0;
      tx_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      we_q        <= we_d;
      dat_q       <= dat_d;
      tx_req_q    <= tx_req_d;
      tx_data_q   <= tx_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      stray_q     <= stray_d;
    end
  end

  assign tx_req_o    = tx_req_q;
  assign tx_data_o   = tx_data_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign stray_o     = stray_q;

endmodule

// File: tb/tb_host_async.sv
module tb_host_async;

  localparam logic [7:0]  AckByte    = 8'h01;
  localparam int unsigned TimeoutCyc = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready_o;
  logic       req_we;
  logic [3:0] req_adr;
  logic [7:0] req_dat;
  logic       rsp_valid_o;
  logic [7:0] rsp_dat_o;
  logic       rsp_err_o;
  logic       tx_req_o;
  logic       tx_ready;
  logic [7:0] tx_data_o;
  logic       rx_req;
  logic [7:0] rx_data;
  logic       stray_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Last response seen, used to check that rsp_dat_o / rsp_err_o hold.
  logic [7:0] last_dat;
  logic       last_err;

  always #5 clk = ~clk;

  host_async #(
    .TimeoutCycles(TimeoutCyc),
    .WriteAckByte (AckByte)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready_o),
    .req_we_i   (req_we),
    .req_adr_i  (req_adr),
    .req_dat_i  (req_dat),
    .rsp_valid_o(rsp_valid_o),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .tx_req_o   (tx_req_o),
    .tx_ready_i (tx_ready),
    .tx_data_o  (tx_data_o),
    .rx_req_i   (rx_req),
    .rx_data_i  (rx_data),
    .stray_o    (stray_o)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; the command byte must appear one cycle later.
  task automatic issue(input logic we, input logic [3:0] adr, input logic [7:0] dat);
    check("idle_ready", 8'(req_ready_o), 8'h01);
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_dat   = dat;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_adr   = 4'($urandom);
    req_dat   = 8'($urandom);
    check("busy_ready", 8'(req_ready_o), 8'h00);
    check("tx_req_up", 8'(tx_req_o), 8'h01);
  endtask

  // Stall the byte for `stall` cycles (optionally with a stray RX strobe), then accept it.
  task automatic push_byte(input logic [7:0] expb, input int stall, input int stray_at,
                           input bit rx_at_accept);
    for (int k = 0; k < stall; k++) begin
      tx_ready = 1'b0;
      rx_req   = (k == stray_at);
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
      rx_req = 1'b0;
      check("hold_req", 8'(tx_req_o), 8'h01);
      check("hold_dat", tx_data_o, expb);
      check("stall_stray", 8'(stray_o), 8'(k == stray_at));
      check("stall_no_rsp", 8'(rsp_valid_o), 8'h00);
    end
    check("tx_byte", tx_data_o, expb);
    check("tx_req", 8'(tx_req_o), 8'h01);
    tx_ready = 1'b1;
    rx_req   = rx_at_accept;
    rx_data  = 8'($urandom);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    rx_req   = 1'b0;
    check("accept_stray", 8'(stray_o), 8'(rx_at_accept));
    check("accept_no_rsp", 8'(rsp_valid_o), 8'h00);
  endtask

  task automatic respond(input logic we, input logic [7:0] rsp, input int wait_cyc);
    logic exp_err;
    exp_err = we && (rsp != AckByte);
    check("tx_dropped", 8'(tx_req_o), 8'h00);
    for (int k = 0; k < wait_cyc; k++) begin
      @(posedge clk); #1;
      check("wait_no_rsp", 8'(rsp_valid_o), 8'h00);
      check("wait_busy", 8'(req_ready_o), 8'h00);
    end
    rx_req  = 1'b1;
    rx_data = rsp;
    @(posedge clk); #1;
    rx_req  = 1'b0;
    rx_data = 8'($urandom);
    check("rsp_valid", 8'(rsp_valid_o), 8'h01);
    check("rsp_dat", rsp_dat_o, rsp);
    check("rsp_err", 8'(rsp_err_o), 8'(exp_err));
    check("rsp_ready", 8'(req_ready_o), 8'h01);
    check("rsp_no_stray", 8'(stray_o), 8'h00);
    last_dat = rsp;
    last_err = exp_err;
    @(posedge clk); #1;
    check("rsp_pulse_end", 8'(rsp_valid_o), 8'h00);
    check("rsp_dat_hold", rsp_dat_o, last_dat);
    check("rsp_err_hold", 8'(rsp_err_o), 8'(last_err));
  endtask

  // Whole transaction; the expected TX byte sequence comes straight from the command format.
  task automatic do_txn(input logic we, input logic [3:0] adr, input logic [7:0] dat,
                        input logic [7:0] rsp, input int cmd_stall, input int stray_at,
                        input bit rx_last);
    logic [7:0] q[$];
    q.push_back({we, 3'b000, adr});
    if (we) q.push_back(dat);
    issue(we, adr, dat);
    for (int i = 0; i < q.size(); i++) begin
      push_byte(q[i], (i == 0) ? cmd_stall : int'($urandom_range(3, 0)),
                (i == 0) ? stray_at : -1, rx_last && (i == q.size() - 1));
    end
    respond(we, rsp, int'($urandom_range(4, 0)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_adr   = '0;
    req_dat   = '0;
    tx_ready  = 1'b0;
    rx_req    = 1'b0;
    rx_data   = '0;
    #1;
    check("rst_ready", 8'(req_ready_o), 8'h01);
    check("rst_rsp_valid", 8'(rsp_valid_o), 8'h00);
    check("rst_rsp_dat", rsp_dat_o, 8'h00);
    check("rst_rsp_err", 8'(rsp_err_o), 8'h00);
    check("rst_tx_req", 8'(tx_req_o), 8'h00);
    check("rst_tx_data", tx_data_o, 8'h00);
    check("rst_stray", 8'(stray_o), 8'h00);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    do_txn(1'b0, 4'h3, 8'h00, 8'hA5, 0, -1, 1'b0);
    do_txn(1'b1, 4'hF, 8'h5A, 8'h01, 0, -1, 1'b0);
    do_txn(1'b1, 4'h2, 8'h11, 8'h00, 0, -1, 1'b0);
    do_txn(1'b1, 4'h3, 8'h77, 8'h01, 5, 2, 1'b0);
    // RX byte coinciding with the last TX acceptance is stray, not the response.
    do_txn(1'b0, 4'h9, 8'h00, 8'h3E, 1, -1, 1'b1);

    // Stray byte while idle: no state change, no response.
    rx_req  = 1'b1;
    rx_data = 8'h99;
    @(posedge clk); #1;
    rx_req = 1'b0;
    check("idle_stray", 8'(stray_o), 8'h01);
    check("idle_stray_ready", 8'(req_ready_o), 8'h01);
    check("idle_stray_no_rsp", 8'(rsp_valid_o), 8'h00);
    check("idle_stray_dat_hold", rsp_dat_o, last_dat);
    @(posedge clk); #1;
    check("idle_stray_end", 8'(stray_o), 8'h00);

`ifdef HOST_ASYNC_TIMEOUT_EN
    issue(1'b0, 4'h7, 8'h00);
    push_byte(8'h07, 0, -1, 1'b0);
    for (int k = 0; k < int'(TimeoutCyc) - 1; k++) begin
      @(posedge clk); #1;
      check("to_wait", 8'(rsp_valid_o), 8'h00);
    end
    @(posedge clk); #1;
    check("to_valid", 8'(rsp_valid_o), 8'h01);
    check("to_err", 8'(rsp_err_o), 8'h01);
    check("to_dat", rsp_dat_o, 8'hFF);
    check("to_ready", 8'(req_ready_o), 8'h01);
    @(posedge clk); #1;
    check("to_pulse_end", 8'(rsp_valid_o), 8'h00);
`else
    // Without the timeout the block must keep waiting well past TimeoutCycles.
    issue(1'b0, 4'h7, 8'h00);
    push_byte(8'h07, 0, -1, 1'b0);
    for (int k = 0; k < int'(TimeoutCyc) + 4; k++) begin
      @(posedge clk); #1;
      check("nto_wait", 8'(rsp_valid_o), 8'h00);
    end
    respond(1'b0, 8'h42, 0);
`endif

    // Reset during the data byte abandons the transaction.
    issue(1'b1, 4'h6, 8'h3C);
    push_byte(8'h86, 0, -1, 1'b0);
    check("sd_dat", tx_data_o, 8'h3C);
    check("sd_req", 8'(tx_req_o), 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx_req", 8'(tx_req_o), 8'h00);
    check("arst_ready", 8'(req_ready_o), 8'h01);
    check("arst_rsp_valid", 8'(rsp_valid_o), 8'h00);
    @(posedge clk); #1;
    check("arst_hold_rsp", 8'(rsp_valid_o), 8'h00);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rsp", 8'(rsp_valid_o), 8'h00);
    check("post_rst_ready", 8'(req_ready_o), 8'h01);
    do_txn(1'b0, 4'hA, 8'h00, 8'h5C, 1, -1, 1'b0);

    // Random transactions.
    for (int n = 0; n < 24; n++) begin
      logic       we;
      logic [3:0] adr;
      logic [7:0] dat, rsp;
      int         stall, stray_at;
      bit         rx_last;
      we       = 1'($urandom);
      adr      = 4'($urandom);
      dat      = 8'($urandom);
      rsp      = (we && ($urandom_range(1, 0) == 1)) ? AckByte : 8'($urandom);
      stall    = int'($urandom_range(3, 0));
      stray_at = int'($urandom_range(3, 0)) - 1;
      rx_last  = ($urandom_range(3, 0) == 0);
      do_txn(we, adr, dat, rsp, stall, stray_at, rx_last);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
